// File: rtl/game_round_controller.sv
// End-of-game timer and per-game bookkeeping (level, score, lives, game-over hold) beside the master FSM.
// Optional GAME_ROUND_CTRL_LEVEL_DOWN_EN: a lost round also drops the level by one (floor 0).
module game_round_controller #(
  parameter int unsigned          TIMER_W     = 26,
  parameter logic [TIMER_W-1:0]   WON_CYCLES  = TIMER_W'(25000000),
  parameter logic [TIMER_W-1:0]   LOST_CYCLES = TIMER_W'(50000000),
  parameter int unsigned          LEVEL_W     = 3,
  parameter int unsigned          START_LIVES = 3,
  parameter int unsigned          DX_W        = 4,
  parameter int unsigned          BASE_DX     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key,
  input  logic               end_of_game_timer_start,
  input  logic               game_won,
  output logic               end_of_game_timer_running,
  output logic [DX_W-1:0]    target_dx,
  output logic [LEVEL_W-1:0] level,
  output logic [7:0]         score,
  output logic [3:0]         lives,
  output logic               game_over
);

  typedef enum logic [1:0] {PLAY, WAIT, OVER_REL, OVER_PRESS} state_t;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = '1;
  localparam logic [DX_W-1:0]    DX_MAX     = '1;
  localparam logic [3:0]         LIVES_INIT = 4'(START_LIVES);

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer;
  logic               round_end;
  logic               new_game;

  function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] l);
    return (l == LEVEL_MAX) ? l : l + LEVEL_W'(1);
  endfunction

`ifdef GAME_ROUND_CTRL_LEVEL_DOWN_EN
  function automatic logic [LEVEL_W-1:0] level_dec(input logic [LEVEL_W-1:0] l);
    return (l == '0) ? l : l - LEVEL_W'(1);
  endfunction
`endif

  function automatic logic [7:0] score_inc(input logic [7:0] s);
    return (s == 8'hFF) ? s : s + 8'd1;
  endfunction

  function automatic logic [3:0] lives_dec(input logic [3:0] n);
    return (n == 4'd0) ? n : n - 4'd1;
  endfunction

  // Speed grows with level but clamps at the widest value target_dx can hold.
  function automatic logic [DX_W-1:0] dx_of(input logic [LEVEL_W-1:0] l);
    int unsigned sum;
    sum = BASE_DX + 32'(l);
    return (sum > 32'(DX_MAX)) ? DX_MAX : DX_W'(sum);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= PLAY;
    else       state <= state_next;
  end

  // A pulse during WAIT restarts the round rather than queueing behind it.
  always_comb begin
    state_next = state;
    round_end  = 1'b0;
    new_game   = 1'b0;
    case (state)
      PLAY: begin
        if (end_of_game_timer_start) begin
          state_next = WAIT;
          round_end  = 1'b1;
        end
      end
      WAIT: begin
        if (end_of_game_timer_start) begin
          round_end = 1'b1;
        end else if (timer == '0) begin
          state_next = (lives == 4'd0) ? OVER_REL : PLAY;
        end
      end
      OVER_REL: begin
        if (!key) state_next = OVER_PRESS;
      end
      OVER_PRESS: begin
        if (key) begin
          state_next = PLAY;
          new_game   = 1'b1;
        end
      end
      default: state_next = PLAY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer     <= '0;
      level     <= '0;
      score     <= '0;
      lives     <= LIVES_INIT;
      target_dx <= DX_W'(BASE_DX);
    end else begin
      target_dx <= dx_of(level);
      if (round_end) begin
        timer <= game_won ? WON_CYCLES : LOST_CYCLES;
        if (game_won) begin
          level <= level_inc(level);
          score <= score_inc(score);
        end else begin
          lives <= lives_dec(lives);
`ifdef GAME_ROUND_CTRL_LEVEL_DOWN_EN
          level <= level_dec(level);
`endif
        end
      end else if (new_game) begin
        level <= '0;
        score <= '0;
        lives <= LIVES_INIT;
      end else if (state == WAIT && timer != '0) begin
        timer <= timer - TIMER_W'(1);
      end
    end
  end

  assign game_over = (state == OVER_REL) || (state == OVER_PRESS);
  assign end_of_game_timer_running = game_over || (state == WAIT && timer != '0);

endmodule

// File: tb/tb_game_round_controller.sv
// Bench for game_round_controller: directed scenarios then random traffic against a round-level model.
module tb_game_round_controller;
  localparam int TIMER_W     = 26;
  localparam int LEVEL_W     = 2;
  localparam int DX_W        = 4;
  localparam int BASE_DX     = 1;
  localparam int START_LIVES = 2;
  localparam int WON_N       = 4;
  localparam int LOST_N      = 6;
  localparam int LEVEL_TOP   = (1 << LEVEL_W) - 1;
  localparam int DX_TOP      = (1 << DX_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               key;
  logic               start;
  logic               won;
  logic               running;
  logic [DX_W-1:0]    target_dx;
  logic [LEVEL_W-1:0] level;
  logic [7:0]         score;
  logic [3:0]         lives;
  logic               game_over;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: remaining cycles of the post-round wait (0 = not waiting), game-over hold, key seen released.
  int m_wait, m_over, m_released, m_level, m_score, m_lives, m_dx;

  game_round_controller #(
    .TIMER_W(TIMER_W), .WON_CYCLES(26'd4), .LOST_CYCLES(26'd6), .LEVEL_W(LEVEL_W),
    .START_LIVES(START_LIVES), .DX_W(DX_W), .BASE_DX(BASE_DX)
  ) dut (
    .clk(clk), .reset(reset), .key(key), .end_of_game_timer_start(start), .game_won(won),
    .end_of_game_timer_running(running), .target_dx(target_dx), .level(level),
    .score(score), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_over = 0; m_released = 0;
    m_level = 0; m_score = 0; m_lives = START_LIVES; m_dx = BASE_DX;
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_edge(input logic k, input logic s, input logic w);
    m_dx = imin(BASE_DX + m_level, DX_TOP);
    if (m_over != 0) begin
      if (m_released == 0) begin
        if (!k) m_released = 1;
      end else if (k) begin
        m_over = 0; m_released = 0;
        m_level = 0; m_score = 0; m_lives = START_LIVES;
      end
    end else if (s) begin
      m_wait = (w ? WON_N : LOST_N) + 1;
      if (w) begin
        m_level = imin(m_level + 1, LEVEL_TOP);
        m_score = imin(m_score + 1, 255);
      end else begin
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
`ifdef GAME_ROUND_CTRL_LEVEL_DOWN_EN
        m_level = (m_level > 0) ? m_level - 1 : 0;
`endif
      end
    end else if (m_wait == 1) begin
      m_wait = 0;
      if (m_lives == 0) m_over = 1;
    end else if (m_wait > 1) begin
      m_wait--;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".running"},   32'(running),   ((m_over != 0) || (m_wait > 1)) ? 1 : 0);
    chk({tag, ".game_over"}, 32'(game_over), (m_over != 0) ? 1 : 0);
    chk({tag, ".level"},     32'(level),     m_level);
    chk({tag, ".score"},     32'(score),     m_score);
    chk({tag, ".lives"},     32'(lives),     m_lives);
    chk({tag, ".dx"},        32'(target_dx), m_dx);
  endtask

  task automatic step(input string tag, input logic k, input logic s, input logic w);
    key = k; start = s; won = w;
    @(posedge clk);
    model_edge(k, s, w);
    #1;
    check_all(tag);
    start = 1'b0;
  endtask

  task automatic idle(input string tag, input int n, input logic k);
    for (int i = 0; i < n; i++) step(tag, k, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; key = 1'b0; start = 1'b0; won = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;
    idle("idle", 10, 1'b0);

    step("won1", 1'b0, 1'b1, 1'b1);
    idle("won1_wait", 6, 1'b0);
    chk("won1_level", 32'(level), 1);
    chk("won1_dx", 32'(target_dx), 2);

    for (int r = 0; r < 3; r++) begin
      step("won_n", 1'b0, 1'b1, 1'b1);
      idle("won_n_wait", 6, 1'b0);
    end
    chk("lvl_sat", 32'(level), 3);
    chk("score4", 32'(score), 4);
    chk("dx_sat", 32'(target_dx), 4);

    step("lost1", 1'b1, 1'b1, 1'b0);
    idle("lost1_wait", 7, 1'b1);
    chk("lives1", 32'(lives), 1);
    step("lost2", 1'b1, 1'b1, 1'b0);
    idle("lost2_wait", 7, 1'b1);
    idle("over_hold", 3, 1'b1);
    chk("over_flag", 32'(game_over), 1);
    chk("over_running", 32'(running), 1);
    step("over_rel", 1'b0, 1'b0, 1'b0);
    step("over_press", 1'b1, 1'b0, 1'b0);
    chk("newgame_running", 32'(running), 0);
    chk("newgame_lives", 32'(lives), 2);
    chk("newgame_score", 32'(score), 0);

    step("restart_a", 1'b0, 1'b1, 1'b1);
    idle("restart_gap", 2, 1'b0);
    step("restart_b", 1'b0, 1'b1, 1'b1);
    idle("restart_wait", 6, 1'b0);
    chk("restart_score", 32'(score), 2);

    step("rst_mid", 1'b0, 1'b1, 1'b1);
    idle("rst_mid_wait", 2, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    chk("async_running", 32'(running), 0);
    @(posedge clk);
    #1;
    check_all("reset_held");
    reset = 1'b0;
    idle("post_reset", 2, 1'b0);

    for (int r = 0; r < 2; r++) begin
      step("ld_won", 1'b0, 1'b1, 1'b1);
      idle("ld_won_wait", 6, 1'b0);
    end
    step("ld_lost", 1'b0, 1'b1, 1'b0);
    idle("ld_lost_wait", 2, 1'b0);
`ifdef GAME_ROUND_CTRL_LEVEL_DOWN_EN
    chk("ld_level", 32'(level), 1);
    chk("ld_dx", 32'(target_dx), 2);
`else
    chk("ld_level", 32'(level), 2);
    chk("ld_dx", 32'(target_dx), 3);
`endif
    chk("ld_lives", 32'(lives), 1);
    idle("ld_tail", 6, 1'b0);

    for (int c = 0; c < 800; c++) begin
      step("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
